button_input_conditioner: RTL and testbench

//  Receive-side front end for the player button interface (ui_in). Synchronises raw asynchronous

---
 rtl/button_input_conditioner.sv | 165 ++++++++++++++++
 tb/tb_button_input_conditioner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_input_conditioner.sv
// Button receive front end: 2-FF synchroniser, shared debounce prescaler,
// one debounce FSM per channel, registered press/release pulses and a
// registered lowest-index priority report of last cycle's presses.
module button_input_conditioner #(
    parameter int unsigned NUM_BTN  = 8,
    parameter int unsigned TICK_DIV = 16,
    parameter int unsigned DB_COUNT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               press_valid,
    output logic [2:0]         press_code,
    output logic               press_multi
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(DB_COUNT + 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } btn_state_e;

    logic [NUM_BTN-1:0] meta_q, meta_d;
    logic [NUM_BTN-1:0] sync_q, sync_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic               tick;

    btn_state_e         state_q [NUM_BTN];
    btn_state_e         state_d [NUM_BTN];
    logic [CW-1:0]      cnt_q   [NUM_BTN];
    logic [CW-1:0]      cnt_d   [NUM_BTN];

    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;

    logic               valid_q, valid_d;
    logic [2:0]         code_q, code_d;
    logic               multi_q, multi_d;
    logic [3:0]         n_pressed;

    // Synchroniser chain inputs and free-running prescaler
    always_comb begin
        meta_d = btn_raw;
        sync_d = meta_q;
        tick   = (pre_q == PW'(TICK_DIV - 1));
        pre_d  = tick ? '0 : pre_q + PW'(1);
    end

    // Per-channel debounce FSM next state, counter and event pulses
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                RELEASED: begin
                    if (sync_q[i]) begin
                        state_d[i] = PRESS_PEND;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!sync_q[i]) begin
                        state_d[i] = RELEASED;
                    end else if (tick) begin
                        if (cnt_q[i] == CW'(DB_COUNT - 1)) begin
                            state_d[i] = PRESSED;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
                PRESSED: begin
                    if (!sync_q[i]) begin
                        state_d[i] = RELEASE_PEND;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_PEND: begin
                    if (sync_q[i]) begin
                        state_d[i] = PRESSED;
                    end else if (tick) begin
                        if (cnt_q[i] == CW'(DB_COUNT - 1)) begin
                            state_d[i]   = RELEASED;
                            level_d[i]   = 1'b0;
                            release_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                end
            endcase
        end
    end

    // Priority report over the previous cycle's press pulses
    always_comb begin
        valid_d   = |press_q;
        code_d    = '0;
        n_pressed = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            n_pressed = n_pressed + 4'(press_q[i]);
            if (press_q[NUM_BTN - 1 - i]) begin
                code_d = 3'(NUM_BTN - 1 - i);
            end
        end
        multi_d = (n_pressed > 4'd1);
    end

    // State registers, all cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q    <= '0;
            sync_q    <= '0;
            pre_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            multi_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            pre_q     <= pre_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            multi_q   <= multi_d;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign press_valid = valid_q;
    assign press_code  = code_q;
    assign press_multi = multi_q;

endmodule

// File: tb/tb_button_input_conditioner.sv
// Bench for button_input_conditioner: two instances (TICK_DIV 1 and 16)
// share stimulus; a run-length debounce model checks both every cycle,
// and directed scenarios pin exact latencies with literal expectations.
module tb_button_input_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned TD [2] = '{1, 16};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn_raw = 8'h00;
    logic       done = 1'b0;

    logic [7:0] lvl1, prs1, rel1, lvl16, prs16, rel16;
    logic       pv1, multi1, pv16, multi16;
    logic [2:0] code1, code16;

    int unsigned n_vec = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    button_input_conditioner #(.NUM_BTN(8), .TICK_DIV(1), .DB_COUNT(DB)) u_d1 (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1),
        .press_valid(pv1), .press_code(code1), .press_multi(multi1)
    );

    button_input_conditioner #(.NUM_BTN(8), .TICK_DIV(16), .DB_COUNT(DB)) u_d16 (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(lvl16), .btn_press(prs16), .btn_release(rel16),
        .press_valid(pv16), .press_code(code16), .press_multi(multi16)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A channel's accepted level flips at edge k when the synchronised input
    // has disagreed with the level on every edge of the current run starting
    // at edge p, and edge k is the DB-th prescaler tick after p.
    logic [7:0]  raw_hist [$];
    int unsigned ek;
    logic [7:0]  m_lvl [2];
    logic [7:0]  m_prs [2];
    logic [7:0]  m_rel [2];
    logic        m_pv [2];
    logic [2:0]  m_code [2];
    logic        m_multi [2];

    function automatic logic [7:0] sync_at(input int unsigned k);
        return (k >= 3) ? raw_hist[k-2] : 8'h00;
    endfunction

    task automatic model_reset();
        ek = 0;
        raw_hist.delete();
        raw_hist.push_back(8'h00);
        for (int m = 0; m < 2; m++) begin
            m_lvl[m] = '0; m_prs[m] = '0; m_rel[m] = '0;
            m_pv[m] = 1'b0; m_code[m] = '0; m_multi[m] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [7:0] raw);
        logic [7:0]  s, sp, prev, np, nr;
        int unsigned p;
        ek++;
        raw_hist.push_back(raw);
        s = sync_at(ek);
        for (int m = 0; m < 2; m++) begin
            prev = m_prs[m];
            m_pv[m] = (prev != 8'h00);
            m_code[m] = '0;
            for (int i = 7; i >= 0; i--) if (prev[i]) m_code[m] = 3'(i);
            m_multi[m] = ($countones(prev) > 1);
            np = '0;
            nr = '0;
            for (int i = 0; i < 8; i++) begin
                if (s[i] != m_lvl[m][i]) begin
                    p = ek;
                    while (p > 1) begin
                        sp = sync_at(p - 1);
                        if (sp[i] == m_lvl[m][i]) break;
                        p--;
                    end
                    if ((ek % TD[m] == 0) && (ek / TD[m] - p / TD[m] == DB)) begin
                        if (s[i]) np[i] = 1'b1;
                        else      nr[i] = 1'b1;
                    end
                end
            end
            m_lvl[m] = m_lvl[m] ^ (np | nr);
            m_prs[m] = np;
            m_rel[m] = nr;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step(btn_raw);
        end
    end

    // ---------------- every-cycle compare ----------------
    initial begin
        while (!done) begin
            @(negedge clk);
            chk("d1.level",    lvl1,          m_lvl[0]);
            chk("d1.press",    prs1,          m_prs[0]);
            chk("d1.release",  rel1,          m_rel[0]);
            chk("d1.valid",    8'(pv1),       8'(m_pv[0]));
            chk("d1.code",     8'(code1),     8'(m_code[0]));
            chk("d1.multi",    8'(multi1),    8'(m_multi[0]));
            chk("d16.level",   lvl16,         m_lvl[1]);
            chk("d16.press",   prs16,         m_prs[1]);
            chk("d16.release", rel16,         m_rel[1]);
            chk("d16.valid",   8'(pv16),      8'(m_pv[1]));
            chk("d16.code",    8'(code16),    8'(m_code[1]));
            chk("d16.multi",   8'(multi16),   8'(m_multi[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        btn_raw = 8'h00;
        rst_n = 1'b0;
        steps(3);
        rst_n = 1'b1;
    endtask

    int unsigned hold [8];
    int          e, np_cnt, nr_cnt;

    initial begin
        // Reset state
        step();
        chk("rst.level", lvl1, 8'h00);
        chk("rst.press", prs1, 8'h00);
        chk("rst.valid", 8'(pv1), 8'h00);
        do_reset();

        // T1: single press, exact latency and priority report
        btn_raw = 8'h08;
        steps(6);
        chk("t1.press_early", prs1, 8'h00);
        step();
        chk("t1.press", prs1, 8'h08);
        chk("t1.level", lvl1, 8'h08);
        step();
        chk("t1.press_once", prs1, 8'h00);
        chk("t1.valid", 8'(pv1), 8'h01);
        chk("t1.code", 8'(code1), 8'h03);
        chk("t1.multi", 8'(multi1), 8'h00);

        // T2: 3-cycle glitch rejected
        do_reset();
        btn_raw = 8'h01;
        steps(3);
        btn_raw = 8'h00;
        np_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            step();
            if (prs1 != 8'h00) np_cnt++;
        end
        chk("t2.presses", 8'(np_cnt), 8'h00);
        chk("t2.level", lvl1, 8'h00);

        // T3: chatter on bit 5 then stable release
        do_reset();
        btn_raw = 8'h20;
        steps(8);
        chk("t3.held", lvl1, 8'h20);
        np_cnt = 0;
        nr_cnt = 0;
        for (int r = 0; r < 3; r++) begin
            btn_raw = 8'h00;
            for (int j = 0; j < 2; j++) begin
                step(); np_cnt += int'(prs1[5]); nr_cnt += int'(rel1[5]);
            end
            btn_raw = 8'h20;
            for (int j = 0; j < 2; j++) begin
                step(); np_cnt += int'(prs1[5]); nr_cnt += int'(rel1[5]);
            end
        end
        btn_raw = 8'h00;
        e = 0;
        for (int j = 1; j <= 20; j++) begin
            step();
            np_cnt += int'(prs1[5]);
            nr_cnt += int'(rel1[5]);
            if (rel1[5] && e == 0) e = j;
        end
        chk("t3.release_edge", 8'(e), 8'd7);
        chk("t3.releases", 8'(nr_cnt), 8'd1);
        chk("t3.presses", 8'(np_cnt), 8'd0);

        // T4: simultaneous presses
        do_reset();
        btn_raw = 8'b0010_0100;
        steps(7);
        chk("t4.press", prs1, 8'b0010_0100);
        step();
        chk("t4.valid", 8'(pv1), 8'h01);
        chk("t4.code", 8'(code1), 8'h02);
        chk("t4.multi", 8'(multi1), 8'h01);

        // T5: TICK_DIV=16 acceptance; ticks fall on edges 16,32,48,64
        do_reset();
        btn_raw = 8'h01;
        e = 0;
        for (int j = 1; j <= 100; j++) begin
            step();
            if (prs16[0]) begin e = j; break; end
        end
        chk("t5.edge", 8'(e), 8'd64);
        chk("t5.window", 8'(e >= 52 && e <= 67), 8'h01);

        // T6: reset during PRESS_PEND, then during PRESSED
        do_reset();
        btn_raw = 8'h40;
        steps(4);
        rst_n = 1'b0;
        #1;
        chk("t6.pend_level", lvl1, 8'h00);
        steps(2);
        rst_n = 1'b1;
        btn_raw = 8'h02;
        steps(8);
        chk("t6.pressed", lvl1, 8'h02);
        rst_n = 1'b0;
        #1;
        chk("t6.rst_level", lvl1, 8'h00);
        chk("t6.rst_press", prs1, 8'h00);
        steps(2);
        rst_n = 1'b1;
        e = 0;
        nr_cnt = 0;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (rel1 != 8'h00) nr_cnt++;
            if (prs1[1] && e == 0) e = j;
        end
        chk("t6.repress_edge", 8'(e), 8'd7);
        chk("t6.no_release", 8'(nr_cnt), 8'd0);

        // Random phase: per-bit hold times mixing glitches and long holds
        do_reset();
        for (int b = 0; b < 8; b++) hold[b] = $urandom_range(1, 40);
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if (hold[b] == 0) begin
                    btn_raw[b] = ~btn_raw[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                          : $urandom_range(20, 90);
                end else begin
                    hold[b]--;
                end
            end
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                steps(2);
                rst_n = 1'b1;
            end
            step();
        end

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
